// File: rtl/s_mem_arbiter.sv
// Transaction-level round-robin arbiter for the single-port RC4 S-memory.
// The owner keeps the RAM until it drops req; read results are routed back by tag.
module s_mem_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        gnt,
  input  logic [N_REQ-1:0]        acc_valid,
  input  logic [N_REQ-1:0]        acc_we,
  input  logic [N_REQ*ADDR_W-1:0] acc_addr,
  input  logic [N_REQ*DATA_W-1:0] acc_wdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    mem_wren,
  input  logic [DATA_W-1:0]       mem_q,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [1:0]              owner,
  output logic                    busy,
  output logic                    proto_err
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [1:0]             owner_q, owner_d;
  logic [1:0]             last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   perr_q, perr_d;
  logic [RD_LAT-1:0]      tag_vld_q;
  logic [RD_LAT-1:0][1:0] tag_id_q;

  logic       win_found;
  logic [1:0] win_idx;
  int         cand;
  logic       accept;
  logic       viol;
  logic       rd_push;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end else begin
        cand = cand;
      end
      if (!win_found && req[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end else begin
        win_found = win_found;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = OWN;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          last_d           = win_idx;
          busy_d           = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          owner_d = 2'd0;
          busy_d  = 1'b0;
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = 2'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Strobes from non-owners never reach the RAM; they only raise the sticky error.
  assign accept  = acc_valid[owner_q] & gnt_q[owner_q];
  assign viol    = |(acc_valid & ~gnt_q);
  assign rd_push = accept & ~acc_we[owner_q];
  assign perr_d  = perr_q | viol;

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    if (accept) begin
      mem_addr = acc_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      mem_data = acc_wdata[int'(owner_q)*DATA_W +: DATA_W];
      mem_wren = acc_we[owner_q];
    end else begin
      mem_addr = '0;
      mem_data = '0;
      mem_wren = 1'b0;
    end
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (tag_vld_q[RD_LAT-1]) begin
      rd_valid[tag_id_q[RD_LAT-1]] = 1'b1;
      rd_data                      = mem_q;
    end else begin
      rd_valid = '0;
      rd_data  = '0;
    end
  end

  // Read tags travel alongside the RAM pipeline so they outlive the grant.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= 2'd0;
      last_q    <= 2'(N_REQ - 1);
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      tag_vld_q[0] <= rd_push;
      tag_id_q[0]  <= owner_q;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share stimulus;
// each has its own RAM model, and read returns are checked against per-instance queues.
module tb_s_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req, acc_valid, acc_we;
  logic [23:0] acc_addr, acc_wdata;

  logic [2:0] gnt1, gnt2, rd_valid1, rd_valid2;
  logic [1:0] owner1, owner2;
  logic       busy1, busy2, perr1, perr2, mem_wren1, mem_wren2;
  logic [7:0] mem_addr1, mem_addr2, mem_data1, mem_data2;
  logic [7:0] mem_q1, mem_q2, q2_p, rd_data1, rd_data2;

  logic [7:0] ram1 [256];
  logic [7:0] ram2 [256];
  logic [7:0] shadow [256];

  typedef struct {int due; logic [2:0] id; logic [7:0] data;} sb_t;
  sb_t sb1[$];
  sb_t sb2[$];

  typedef struct {logic [2:0] req, av, we, gnt; logic [1:0] own; logic busy;} vec_t;
  localparam int NV = 18;
  vec_t tbl [NV];
  int   rb [7] = '{2, 3, 6, 7, 10, 11, 15};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s_mem_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .CLOCK_50(clk), .reset_n(rst_n), .req(req), .gnt(gnt1),
    .acc_valid(acc_valid), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_wren(mem_wren1), .mem_q(mem_q1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .owner(owner1), .busy(busy1), .proto_err(perr1));

  s_mem_arbiter #(.N_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut2 (
    .CLOCK_50(clk), .reset_n(rst_n), .req(req), .gnt(gnt2),
    .acc_valid(acc_valid), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_wren(mem_wren2), .mem_q(mem_q2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .owner(owner2), .busy(busy2), .proto_err(perr2));

  // Synchronous RAM models with one and two cycles of read latency.
  always @(posedge clk) begin
    if (mem_wren1) ram1[mem_addr1] <= mem_data1;
    mem_q1 <= ram1[mem_addr1];
    if (mem_wren2) ram2[mem_addr2] <= mem_data2;
    q2_p   <= ram2[mem_addr2];
    mem_q2 <= q2_p;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every cycle, each instance either returns the oldest due read or stays silent.
  always @(negedge clk) begin : mon
    sb_t e;
    if (sb1.size() > 0 && sb1[0].due == cyc) begin
      e = sb1.pop_front();
      chk("rd1_valid", {29'd0, rd_valid1}, {29'd0, e.id});
      chk("rd1_data", {24'd0, rd_data1}, {24'd0, e.data});
    end else begin
      chk("rd1_idle", {21'd0, rd_valid1, rd_data1}, 32'd0);
    end
    if (sb2.size() > 0 && sb2[0].due == cyc) begin
      e = sb2.pop_front();
      chk("rd2_valid", {29'd0, rd_valid2}, {29'd0, e.id});
      chk("rd2_data", {24'd0, rd_data2}, {24'd0, e.data});
    end else begin
      chk("rd2_idle", {21'd0, rd_valid2, rd_data2}, 32'd0);
    end
  end

  function automatic vec_t mk(input logic [2:0] r, av, we, g, input logic [1:0] o, input logic b);
    vec_t v;
    v.req = r; v.av = av; v.we = we; v.gnt = g; v.own = o; v.busy = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, av, we, input int k, input logic [7:0] a, d);
    req = r; acc_valid = av; acc_we = we;
    acc_addr = '0; acc_wdata = '0;
    acc_addr[k*8 +: 8] = a;
    acc_wdata[k*8 +: 8] = d;
  endtask

  // Legal access by the current owner k: writes update the shadow, reads are queued.
  task automatic acc(input logic [2:0] r, input int k, input logic w, input logic [7:0] a, d);
    logic [2:0] oh;
    sb_t e;
    oh = 3'b001 << k;
    drive(r, oh, w ? oh : 3'b000, k, a, d);
    if (w) begin
      shadow[a] = d;
    end else begin
      e.id = oh; e.data = shadow[a];
      e.due = cyc + 1; sb1.push_back(e);
      e.due = cyc + 2; sb2.push_back(e);
    end
  endtask

  initial begin
    logic [2:0] prev_g;
    logic [7:0] a, d;
    int k;

    tbl[0]  = mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tbl[1]  = mk(3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1);
    tbl[2]  = mk(3'b111, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1);
    tbl[3]  = mk(3'b111, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1);
    tbl[4]  = mk(3'b110, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tbl[5]  = mk(3'b111, 3'b000, 3'b000, 3'b010, 2'd1, 1'b1);
    tbl[6]  = mk(3'b111, 3'b010, 3'b010, 3'b010, 2'd1, 1'b1);
    tbl[7]  = mk(3'b111, 3'b010, 3'b010, 3'b010, 2'd1, 1'b1);
    tbl[8]  = mk(3'b101, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tbl[9]  = mk(3'b111, 3'b000, 3'b000, 3'b100, 2'd2, 1'b1);
    tbl[10] = mk(3'b111, 3'b100, 3'b100, 3'b100, 2'd2, 1'b1);
    tbl[11] = mk(3'b111, 3'b100, 3'b100, 3'b100, 2'd2, 1'b1);
    tbl[12] = mk(3'b011, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
    tbl[13] = mk(3'b111, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1);
    tbl[14] = mk(3'b001, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1);
    tbl[15] = mk(3'b000, 3'b001, 3'b001, 3'b000, 2'd0, 1'b0);
    tbl[16] = mk(3'b001, 3'b000, 3'b000, 3'b001, 2'd0, 1'b1);
    tbl[17] = mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);

    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {29'd0, gnt1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_owner", {30'd0, owner1}, 32'd0);
    chk("rst_perr", {31'd0, perr1}, 32'd0);
    chk("rst_mem", {15'd0, mem_wren1, mem_addr1, mem_data1}, 32'd0);
    rst_n = 1'b1;

    // Arbitration table: round-robin order, one-cycle turnaround, access on release cycle.
    prev_g = 3'b000;
    for (int i = 0; i < NV; i++) begin
      k = prev_g[1] ? 1 : (prev_g[2] ? 2 : 0);
      a = 8'h20 + 8'(i);
      d = 8'h3C ^ 8'(i * 17);
      drive(tbl[i].req, tbl[i].av, tbl[i].we, k, a, d);
      if (|(tbl[i].av & tbl[i].we & prev_g)) shadow[a] = d;
      #1 chk($sformatf("tbl_wren[%0d]", i), {31'd0, mem_wren1}, {31'd0, |(tbl[i].av & tbl[i].we & prev_g)});
      tick();
      chk($sformatf("tbl_gnt[%0d]", i), {29'd0, gnt1}, {29'd0, tbl[i].gnt});
      chk($sformatf("tbl_owner[%0d]", i), {30'd0, owner1}, {30'd0, tbl[i].own});
      chk($sformatf("tbl_busy[%0d]", i), {31'd0, busy1}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl_gnt2[%0d]", i), {29'd0, gnt2}, {29'd0, tbl[i].gnt});
      prev_g = tbl[i].gnt;
    end

    // Back-to-back readback of the table writes by requester 2.
    drive(3'b100, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("rb_gnt", {29'd0, gnt1}, 32'd4);
    foreach (rb[j]) begin
      acc(3'b100, 2, 1'b0, 8'h20 + 8'(rb[j]), 8'h00);
      tick();
    end
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick(); tick();

    // Owner 1 writes then reads the same address.
    drive(3'b010, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t2_gnt", {29'd0, gnt1}, 32'd2);
    chk("t2_owner", {30'd0, owner1}, 32'd1);
    acc(3'b010, 1, 1'b1, 8'h05, 8'hA7);
    #1 chk("t2_wren", {31'd0, mem_wren1}, 32'd1);
    chk("t2_waddr", {24'd0, mem_addr1}, 32'h05);
    chk("t2_wdata", {24'd0, mem_data1}, 32'hA7);
    tick();
    acc(3'b010, 1, 1'b0, 8'h05, 8'h00);
    #1 chk("t2_rd_wren", {31'd0, mem_wren1}, 32'd0);
    chk("t2_raddr", {24'd0, mem_addr1}, 32'h05);
    tick();
    chk("t2_rdv", {29'd0, rd_valid1}, 32'd2);
    chk("t2_rdd", {24'd0, rd_data1}, 32'hA7);
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t2_rel", {29'd0, gnt1}, 32'd0);

    // Read on owner 0's final cycle returns to 0 after requester 1 is granted.
    drive(3'b001, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t5_gnt0", {29'd0, gnt1}, 32'd1);
    acc(3'b001, 0, 1'b1, 8'h90, 8'h3E); tick();
    acc(3'b010, 0, 1'b0, 8'h90, 8'h00); tick();
    chk("t5_gnt_gap", {29'd0, gnt1}, 32'd0);
    chk("t5_rdv1", {29'd0, rd_valid1}, 32'd1);
    chk("t5_rdd1", {24'd0, rd_data1}, 32'h3E);
    drive(3'b010, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t5_gnt1", {29'd0, gnt2}, 32'd2);
    chk("t5_rdv2", {29'd0, rd_valid2}, 32'd1);
    chk("t5_rdd2", {24'd0, rd_data2}, 32'h3E);
    tick();
    chk("t5_no_rd1", {29'd0, rd_valid2}, 32'd0);
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();

    // Requester 2 strobes a write while 0 owns the memory.
    drive(3'b001, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t4_gnt", {29'd0, gnt1}, 32'd1);
    acc(3'b001, 0, 1'b1, 8'h77, 8'h11); tick();
    drive(3'b001, 3'b100, 3'b100, 2, 8'h77, 8'h55);
    #1 chk("t4_wren", {31'd0, mem_wren1}, 32'd0);
    chk("t4_addr", {24'd0, mem_addr1}, 32'd0);
    chk("t4_perr_pre", {31'd0, perr1}, 32'd0);
    tick();
    chk("t4_perr1", {31'd0, perr1}, 32'd1);
    chk("t4_perr2", {31'd0, perr2}, 32'd1);
    drive(3'b001, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick(); tick();
    chk("t4_perr_sticky", {31'd0, perr1}, 32'd1);
    acc(3'b001, 0, 1'b0, 8'h77, 8'h00); tick();
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();

    // Reset in the middle of a swap with reads in flight.
    drive(3'b010, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t6_gnt", {29'd0, gnt1}, 32'd2);
    acc(3'b010, 1, 1'b0, 8'h05, 8'h00); tick();
    acc(3'b010, 1, 1'b0, 8'h22, 8'h00); tick();
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00);
    sb1.delete();
    sb2.delete();
    #1;
    chk("t6_gnt_rst", {26'd0, gnt1, gnt2}, 32'd0);
    chk("t6_busy_rst", {30'd0, busy1, busy2}, 32'd0);
    chk("t6_rdv_rst", {26'd0, rd_valid1, rd_valid2}, 32'd0);
    chk("t6_perr_rst", {30'd0, perr1, perr2}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    drive(3'b110, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t6_ptr", {29'd0, gnt1}, 32'd2);
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    drive(3'b100, 3'b000, 3'b000, 0, 8'h00, 8'h00); tick();
    chk("t6_gnt2", {29'd0, gnt1}, 32'd4);
    chk("t6_owner2", {30'd0, owner1}, 32'd2);
    chk("t6_busy", {31'd0, busy1}, 32'd1);
    drive(3'b000, 3'b000, 3'b000, 0, 8'h00, 8'h00);
    repeat (4) tick();

    chk("sb1_drain", sb1.size(), 32'd0);
    chk("sb2_drain", sb2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
